// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM: opcode and
// funct3 constants, state encodings, ALU mux/op codes and the Moore output
// bundle together with its per-state decode.
package multicycle_ctrl_pkg;

  // Opcodes (IR[6:0]) of the supported instruction subset
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 (IR[14:12]) values accepted for memory ops and branches
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  // ALU operand A select
  localparam logic [1:0] ALU_SRC_A_PC     = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // 4-bit state encoding; codes 11..15 are unused and recover to ST_FAULT
  typedef enum logic [3:0] {
    ST_START    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_FAULT    = 4'd10
  } state_e;

  // Outputs that depend on the state alone
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_write_cond;
    logic       retire;
    logic       fault;
  } moore_out_t;

  // Per-state Moore output table; anything not listed stays 0
  function automatic moore_out_t moore_decode(input state_e s);
    moore_out_t o;
    o = '0;
    case (s)
      ST_FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_a = ALU_SRC_A_PC;
        o.alu_src_b = ALU_SRC_B_FOUR;
        o.alu_op    = ALU_OP_ADD;
      end
      ST_DECODE: begin
        // ALUOut captures the branch target old_pc + imm
        o.alu_src_a = ALU_SRC_A_OLD_PC;
        o.alu_src_b = ALU_SRC_B_IMM;
        o.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_ADDR: begin
        o.alu_src_a = ALU_SRC_A_RS1;
        o.alu_src_b = ALU_SRC_B_IMM;
        o.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
      end
      ST_MEM_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
        o.retire     = 1'b1;
      end
      ST_MEM_WR: begin
        o.mem_req = 1'b1;
        o.mem_we  = 1'b1;
        o.iord    = 1'b1;
      end
      ST_EXEC_R: begin
        o.alu_src_a = ALU_SRC_A_RS1;
        o.alu_src_b = ALU_SRC_B_RS2;
        o.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        o.reg_write = 1'b1;
        o.retire    = 1'b1;
      end
      ST_BRANCH: begin
        o.alu_src_a     = ALU_SRC_A_RS1;
        o.alu_src_b     = ALU_SRC_B_RS2;
        o.alu_op        = ALU_OP_SUB;
        o.pc_source     = 1'b1;
        o.pc_write_cond = 1'b1;
        o.retire        = 1'b1;
      end
      ST_FAULT: begin
        o.fault = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts memory wait cycles for the current access and flags the cycle in
// which the wait would reach TIMEOUT. TIMEOUT = 0 disables the limit.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Value of the count during the wait cycle that brings it to TIMEOUT
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Wait-cycle counter: clear has priority, saturates instead of wrapping
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (lw, sw, beq, R-type).
// Sequences the shared memory, IR, PC, ALU and register file, with a memory
// wait-state handshake, wait timeout, illegal-op trap and retire counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic             pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             fault
);

  state_e           state_q, state_d;
  moore_out_t       out_q;
  logic             timer_clear;
  logic             timer_en;
  logic             timeout_hit;
  logic             pc_write;
  logic [CNT_W-1:0] retire_cnt_q;

  // Next-state decode; mem_ready wins over a timeout in the same cycle
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch appears.
    state_d = state_q;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_DECODE;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == F3_LW_SW))
          state_d = ST_MEM_ADDR;
        else if (opcode == OP_RTYPE)
          state_d = ST_EXEC_R;
        else if ((opcode == OP_BRANCH) && (funct3 == F3_BEQ))
          state_d = ST_BRANCH;
        else
          state_d = ST_FAULT;
      end
      ST_MEM_ADDR: state_d = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)        state_d = ST_MEM_WB;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_MEM_WB: state_d = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready)        state_d = ST_FETCH;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_EXEC_R: state_d = ST_R_WB;
      ST_R_WB:   state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // State register with Moore outputs registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= moore_decode(state_d);
    end
  end

  // Timer restarts on entry to each memory-access state and counts stalls
  assign timer_clear = (state_d != state_q) &&
                       (state_d inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR});
  assign timer_en    = out_q.mem_req && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timeout_hit)
  );

  // Outputs that fire on the mem_ready cycle of an access
  assign pc_write = (state_q == ST_FETCH) && mem_ready;
  assign ir_write = pc_write;
  assign pc_en    = pc_write || (out_q.pc_write_cond && zero);
  assign retire   = out_q.retire || ((state_q == ST_MEM_WR) && mem_ready);

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign mem_req    = out_q.mem_req;
  assign mem_we     = out_q.mem_we;
  assign iord       = out_q.iord;
  assign pc_source  = out_q.pc_source;
  assign alu_src_a  = out_q.alu_src_a;
  assign alu_src_b  = out_q.alu_src_b;
  assign alu_op     = out_q.alu_op;
  assign reg_write  = out_q.reg_write;
  assign mem_to_reg = out_q.mem_to_reg;
  assign fault      = out_q.fault;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and compares every output against a hand-written table.
module tb_multicycle_ctrl;

  typedef enum {
    P_START, P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_RD, P_MEM_WB,
    P_MEM_WR, P_EXEC_R, P_R_WB, P_BRANCH, P_FAULT
  } phase_e;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, retire, fault;
  logic [3:0] retire_cnt;
  logic [15:0] outs;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] cnt_model;

  multicycle_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .fault      (fault)
  );

  assign outs = {mem_req, mem_we, iord, ir_write, pc_en, pc_source,
                 alu_src_a, alu_src_b, alu_op,
                 reg_write, mem_to_reg, retire, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Expected output vector per state, written from the control table:
  // {mem_req, mem_we, iord, ir_write, pc_en, pc_source, src_a, src_b, alu_op,
  //  reg_write, mem_to_reg, retire, fault}
  function automatic logic [15:0] expect_outs(input phase_e p, input logic mr, input logic z);
    logic [15:0] v;
    v = '0;
    case (p)
      P_FETCH:    v = {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 2'b00, 2'b01, 2'b00, 4'b0000};
      P_DECODE:   v = {6'b000000, 2'b01, 2'b10, 2'b00, 4'b0000};
      P_MEM_ADDR: v = {6'b000000, 2'b10, 2'b10, 2'b00, 4'b0000};
      P_MEM_RD:   v = {6'b101000, 6'b000000, 4'b0000};
      P_MEM_WB:   v = {6'b000000, 6'b000000, 4'b1110};
      P_MEM_WR:   v = {6'b111000, 6'b000000, 2'b00, mr, 1'b0};
      P_EXEC_R:   v = {6'b000000, 2'b10, 2'b00, 2'b10, 4'b0000};
      P_R_WB:     v = {6'b000000, 6'b000000, 4'b1010};
      P_BRANCH:   v = {4'b0000, z, 1'b1, 2'b10, 2'b00, 2'b01, 4'b0010};
      P_FAULT:    v = 16'h0001;
      default:    v = 16'h0000;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs and counter, advance the model
  task automatic cycle(input string tag, input phase_e p, input logic mr, input logic z);
    logic [15:0] e;
    mem_ready = mr;
    zero      = z;
    #1;
    e = expect_outs(p, mr, z);
    check({tag, "_outs"}, 32'(outs), 32'(e));
    check({tag, "_cnt"}, 32'(retire_cnt), 32'(cnt_model));
    @(posedge clk);
    if (rst)       cnt_model = '0;
    else if (e[1]) cnt_model = cnt_model + 4'd1;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    cnt_model = '0;

    // Reset held two cycles, then release: START then FETCH
    @(negedge clk);
    cycle("rst_a", P_START, 1'b1, 1'b0);
    cycle("rst_b", P_START, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("start", P_START, 1'b1, 1'b0);

    // lw, no wait states: 5 cycles
    set_instr(7'b0000011, 3'b010);
    cycle("lw_fetch", P_FETCH,    1'b1, 1'b0);
    cycle("lw_dec",   P_DECODE,   1'b1, 1'b0);
    cycle("lw_addr",  P_MEM_ADDR, 1'b1, 1'b0);
    cycle("lw_rd",    P_MEM_RD,   1'b1, 1'b0);
    cycle("lw_wb",    P_MEM_WB,   1'b1, 1'b0);
    check("lw_retired", 32'(retire_cnt), 32'd1);

    // sw with three wait cycles in MEM_WR (still under the 4-cycle limit)
    set_instr(7'b0100011, 3'b010);
    cycle("sw_fetch", P_FETCH,    1'b1, 1'b0);
    cycle("sw_dec",   P_DECODE,   1'b1, 1'b0);
    cycle("sw_addr",  P_MEM_ADDR, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("sw_wait", P_MEM_WR, 1'b0, 1'b0);
    cycle("sw_ready", P_MEM_WR, 1'b1, 1'b0);

    // beq taken (zero=1); zero also high in DECODE where it must not load PC
    set_instr(7'b1100011, 3'b000);
    cycle("beq1_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("beq1_dec",   P_DECODE, 1'b1, 1'b1);
    cycle("beq1_br",    P_BRANCH, 1'b1, 1'b1);
    // beq not taken
    cycle("beq0_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("beq0_dec",   P_DECODE, 1'b1, 1'b0);
    cycle("beq0_br",    P_BRANCH, 1'b1, 1'b0);

    // R-type with fetch stalled three cycles, ready on the 4th (limit) cycle
    set_instr(7'b0110011, 3'b000);
    for (int i = 0; i < 3; i++) cycle("r_fwait", P_FETCH, 1'b0, 1'b0);
    cycle("r_fready4", P_FETCH,  1'b1, 1'b0);
    cycle("r_dec",     P_DECODE, 1'b1, 1'b0);
    cycle("r_exec",    P_EXEC_R, 1'b1, 1'b0);
    cycle("r_wb",      P_R_WB,   1'b1, 1'b0);

    // Twelve more R-types push the 4-bit counter past 15 -> wraps
    for (int i = 0; i < 12; i++) begin
      set_instr(7'b0110011, 3'(i));
      cycle("rl_fetch", P_FETCH,  1'b1, 1'b0);
      cycle("rl_dec",   P_DECODE, 1'b1, 1'b0);
      cycle("rl_exec",  P_EXEC_R, 1'b1, 1'b0);
      cycle("rl_wb",    P_R_WB,   1'b1, 1'b0);
    end
    check("cnt_wrapped", 32'(retire_cnt), 32'd1);

    // Reset mid-lw: instruction aborted, counter back to 0
    set_instr(7'b0000011, 3'b010);
    cycle("ab_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("ab_dec",   P_DECODE, 1'b1, 1'b0);
    rst = 1'b1;
    cycle("ab_addr",  P_MEM_ADDR, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("ab_start", P_START, 1'b1, 1'b0);

    // Illegal opcode 0010011 -> sticky FAULT until reset
    set_instr(7'b0010011, 3'b000);
    cycle("ill_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("ill_dec",   P_DECODE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ill_fault", P_FAULT, 1'b1, 1'b1);
    rst = 1'b1;
    cycle("ill_rst", P_FAULT, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("ill_start", P_START, 1'b1, 1'b0);

    // beq with funct3=001 -> FAULT
    set_instr(7'b1100011, 3'b001);
    cycle("bne_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("bne_dec",   P_DECODE, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cycle("bne_fault", P_FAULT, 1'b1, 1'b1);
    rst = 1'b1;
    cycle("bne_rst", P_FAULT, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("bne_start", P_START, 1'b1, 1'b0);

    // Load opcode with wrong funct3 -> FAULT
    set_instr(7'b0000011, 3'b000);
    cycle("lwf3_fetch", P_FETCH,  1'b1, 1'b0);
    cycle("lwf3_dec",   P_DECODE, 1'b1, 1'b0);
    cycle("lwf3_fault", P_FAULT,  1'b1, 1'b0);
    rst = 1'b1;
    cycle("lwf3_rst", P_FAULT, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("lwf3_start", P_START, 1'b1, 1'b0);

    // Fetch never answered: FAULT after 4 wait cycles, mem_req drops
    set_instr(7'b0110011, 3'b000);
    for (int i = 0; i < 4; i++) cycle("to_wait", P_FETCH, 1'b0, 1'b0);
    cycle("to_fault0", P_FAULT, 1'b0, 1'b0);
    cycle("to_fault1", P_FAULT, 1'b1, 1'b0);
    rst = 1'b1;
    cycle("to_rst", P_FAULT, 1'b1, 1'b0);
    rst = 1'b0;
    cycle("to_start", P_START, 1'b1, 1'b0);
    cycle("to_fetch", P_FETCH, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
